capture_stream_arbiter: RTL and testbench

- Packet-granular 2:1 AXI-Stream arbiter. It merges the forwarded stream and the duplicated capture stream from the packet duplicator onto one master port toward the DMA/output queues.
- Never interleaves beats of different packets.
- Selects inputs by round-robin or by strict priority, chosen by a register input.
- Optionally keeps per-input packet counters for the read-only register bank.

---
 rtl/capture_stream_arbiter.sv | 131 +++++++++++++
 tb/tb_capture_stream_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_stream_arbiter.sv
// Purpose: packet-granular 2:1 AXI-Stream merge of the forward (0) and capture (1) streams.
// Latency: one arbitration cycle in IDLE, then zero-latency combinational pass-through.
// Backpressure: m_axis_tready reaches only the granted slave; grant held until accepted tlast.
// Build option: define CAPTURE_ARB_PKT_COUNTERS_EN to build the per-input packet counters.
module capture_stream_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_0,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
    input  logic                              s_axis_tvalid_0,
    output logic                              s_axis_tready_0,
    input  logic                              s_axis_tlast_0,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_1,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
    input  logic                              s_axis_tvalid_1,
    output logic                              s_axis_tready_1,
    input  logic                              s_axis_tlast_1,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    input  logic                              cfg_strict_prio,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_count_0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_count_1
);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_served_q, last_served_d;
    logic   pkt_done;

    // Accepted end-of-packet beat on the granted input
    assign pkt_done = (state_q == PKT) & m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // State, grant and round-robin history registers
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_served_q <= last_served_d;
        end
    end

    // Next state: arbitrate in IDLE, hold the grant until the tlast beat is accepted
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_served_d = last_served_q;
        case (state_q)
            IDLE: begin
                if (s_axis_tvalid_0 | s_axis_tvalid_1) begin
                    state_d = PKT;
                    if (cfg_strict_prio)
                        grant_d = ~s_axis_tvalid_0;
                    else if (s_axis_tvalid_0 & s_axis_tvalid_1)
                        grant_d = ~last_served_q;
                    else
                        grant_d = s_axis_tvalid_1;
                end
            end
            PKT: begin
                if (pkt_done) begin
                    state_d       = IDLE;
                    last_served_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: datapath always muxed from the grant; valid/ready only live in PKT
    always_comb begin
        m_axis_tdata    = grant_q ? s_axis_tdata_1 : s_axis_tdata_0;
        m_axis_tstrb    = grant_q ? s_axis_tstrb_1 : s_axis_tstrb_0;
        m_axis_tuser    = grant_q ? s_axis_tuser_1 : s_axis_tuser_0;
        m_axis_tlast    = grant_q ? s_axis_tlast_1 : s_axis_tlast_0;
        m_axis_tvalid   = 1'b0;
        s_axis_tready_0 = 1'b0;
        s_axis_tready_1 = 1'b0;
        if (state_q == PKT) begin
            m_axis_tvalid   = grant_q ? s_axis_tvalid_1 : s_axis_tvalid_0;
            s_axis_tready_0 = ~grant_q & m_axis_tready;
            s_axis_tready_1 = grant_q & m_axis_tready;
        end
    end

`ifdef CAPTURE_ARB_PKT_COUNTERS_EN
    localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_ONE = {{(C_S_AXI_DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [C_S_AXI_DATA_WIDTH-1:0] cnt_0_q, cnt_1_q;

    // Per-input completed-packet counters, wrapping modulo 2^width
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            cnt_0_q <= '0;
            cnt_1_q <= '0;
        end else if (pkt_done) begin
            if (grant_q)
                cnt_1_q <= cnt_1_q + CNT_ONE;
            else
                cnt_0_q <= cnt_0_q + CNT_ONE;
        end
    end

    assign pkt_count_0 = cnt_0_q;
    assign pkt_count_1 = cnt_1_q;
`else
    assign pkt_count_0 = '0;
    assign pkt_count_1 = '0;
`endif

endmodule

// File: tb/tb_capture_stream_arbiter.sv
// Purpose: directed self-checking bench for capture_stream_arbiter.
// Latency: checks the one-cycle arbitration gap and zero-latency pass-through.
// Backpressure: exercises downstream stalls, source valid drops and reset mid-packet.
module tb_capture_stream_arbiter;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int RW = 32;
`ifdef CAPTURE_ARB_PKT_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            axi_aclk = 1'b0;
    logic            axi_aresetn;
    logic [DW-1:0]   s_axis_tdata_0, s_axis_tdata_1;
    logic [DW/8-1:0] s_axis_tstrb_0, s_axis_tstrb_1;
    logic [UW-1:0]   s_axis_tuser_0, s_axis_tuser_1;
    logic            s_axis_tvalid_0, s_axis_tvalid_1;
    logic            s_axis_tready_0, s_axis_tready_1;
    logic            s_axis_tlast_0, s_axis_tlast_1;
    logic [DW-1:0]   m_axis_tdata;
    logic [DW/8-1:0] m_axis_tstrb;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic            cfg_strict_prio;
    logic [RW-1:0]   pkt_count_0, pkt_count_1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 axi_aclk = ~axi_aclk;

    capture_stream_arbiter dut (
        .axi_aclk        (axi_aclk),
        .axi_aresetn     (axi_aresetn),
        .s_axis_tdata_0  (s_axis_tdata_0),
        .s_axis_tstrb_0  (s_axis_tstrb_0),
        .s_axis_tuser_0  (s_axis_tuser_0),
        .s_axis_tvalid_0 (s_axis_tvalid_0),
        .s_axis_tready_0 (s_axis_tready_0),
        .s_axis_tlast_0  (s_axis_tlast_0),
        .s_axis_tdata_1  (s_axis_tdata_1),
        .s_axis_tstrb_1  (s_axis_tstrb_1),
        .s_axis_tuser_1  (s_axis_tuser_1),
        .s_axis_tvalid_1 (s_axis_tvalid_1),
        .s_axis_tready_1 (s_axis_tready_1),
        .s_axis_tlast_1  (s_axis_tlast_1),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tstrb    (m_axis_tstrb),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .cfg_strict_prio (cfg_strict_prio),
        .pkt_count_0     (pkt_count_0),
        .pkt_count_1     (pkt_count_1)
    );

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Beat payload unique per source, packet and beat
    function automatic logic [DW-1:0] enc(input int src, input int pkt, input int beat);
        logic [DW-1:0] r;
        r = '0;
        r[31:0]    = 32'hD000_0000 | 32'(src << 16) | 32'(pkt << 8) | 32'(beat);
        r[255:224] = ~r[31:0];
        return r;
    endfunction

    function automatic logic [UW-1:0] usr(input logic [DW-1:0] d);
        return {d[255:192], d[63:0] ^ 64'h5A5A_0000_0000_A5A5};
    endfunction

    function automatic logic [DW/8-1:0] stb(input logic [DW-1:0] d);
        return d[31:0] ^ 32'h0F0F_F0F0;
    endfunction

    task automatic set_src(input int i, input bit vld, input int pkt, input int beat, input bit last);
        if (i == 0) begin
            s_axis_tvalid_0 = vld;
            s_axis_tdata_0  = enc(0, pkt, beat);
            s_axis_tuser_0  = usr(enc(0, pkt, beat));
            s_axis_tstrb_0  = stb(enc(0, pkt, beat));
            s_axis_tlast_0  = last;
        end else begin
            s_axis_tvalid_1 = vld;
            s_axis_tdata_1  = enc(1, pkt, beat);
            s_axis_tuser_1  = usr(enc(1, pkt, beat));
            s_axis_tstrb_1  = stb(enc(1, pkt, beat));
            s_axis_tlast_1  = last;
        end
    endtask

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic do_reset();
        axi_aresetn = 1'b0;
        set_src(0, 1'b0, 0, 0, 1'b0);
        set_src(1, 1'b0, 0, 0, 1'b0);
        m_axis_tready = 1'b1;
        repeat (2) @(posedge axi_aclk);
        #1;
        axi_aresetn = 1'b1;
    endtask

    // Both inputs continuously offer 2-beat packets; check 8 output beats in order
    task automatic run_both(input bit strict);
        int bt0 = 0, bt1 = 0, pk0 = 0, pk1 = 0, nseen = 0, p;
        bit hs0, hs1;
        for (int cyc = 0; cyc < 60 && nseen < 8; cyc++) begin
            set_src(0, 1'b1, pk0, bt0, bt0 == 1);
            set_src(1, 1'b1, pk1, bt1, bt1 == 1);
            settle();
            if (m_axis_tvalid && m_axis_tready) begin
                p = nseen / 2;
                chk($sformatf("s%0d_beat%0d_dat", strict, nseen), m_axis_tdata,
                    enc(strict ? 0 : p % 2, strict ? p : p / 2, nseen % 2));
                chk($sformatf("s%0d_beat%0d_last", strict, nseen), 256'(m_axis_tlast), 256'(nseen % 2 == 1));
                nseen++;
            end
            hs0 = s_axis_tvalid_0 & s_axis_tready_0;
            hs1 = s_axis_tvalid_1 & s_axis_tready_1;
            tick();
            if (hs0) begin
                if (bt0 == 1) pk0++;
                bt0 = 1 - bt0;
            end
            if (hs1) begin
                if (bt1 == 1) pk1++;
                bt1 = 1 - bt1;
            end
        end
        chk($sformatf("s%0d_beats_seen", strict), 256'(nseen), 256'(8));
        set_src(0, 1'b0, 0, 0, 1'b0);
        set_src(1, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, nseen;
        bit t0_bad, hs;

        // Reset state before any clock edge
        axi_aresetn     = 1'b0;
        cfg_strict_prio = 1'b0;
        m_axis_tready   = 1'b1;
        set_src(0, 1'b0, 0, 0, 1'b0);
        set_src(1, 1'b0, 0, 0, 1'b0);
        #1;
        chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("rst_tready_0", 256'(s_axis_tready_0), 256'(0));
        chk("rst_tready_1", 256'(s_axis_tready_1), 256'(0));
        chk("rst_count_0", 256'(pkt_count_0), 256'(0));
        chk("rst_count_1", 256'(pkt_count_1), 256'(0));

        // Input 0 sends a 3-beat packet
        do_reset();
        set_src(0, 1'b1, 0, 0, 1'b0);
        settle();
        chk("t1_idle_vld", 256'(m_axis_tvalid), 256'(0));
        chk("t1_idle_rdy0", 256'(s_axis_tready_0), 256'(0));
        tick();
        for (int i = 0; i < 3; i++) begin
            set_src(0, 1'b1, 0, i, i == 2);
            settle();
            chk($sformatf("t1_b%0d_vld", i), 256'(m_axis_tvalid), 256'(1));
            chk($sformatf("t1_b%0d_dat", i), m_axis_tdata, enc(0, 0, i));
            chk($sformatf("t1_b%0d_usr", i), 256'(m_axis_tuser), 256'(usr(enc(0, 0, i))));
            chk($sformatf("t1_b%0d_stb", i), 256'(m_axis_tstrb), 256'(stb(enc(0, 0, i))));
            chk($sformatf("t1_b%0d_last", i), 256'(m_axis_tlast), 256'(i == 2));
            chk($sformatf("t1_b%0d_rdy1", i), 256'(s_axis_tready_1), 256'(0));
            tick();
        end
        set_src(0, 1'b0, 0, 0, 1'b0);
        settle();
        chk("t1_end_vld", 256'(m_axis_tvalid), 256'(0));
        chk("t1_count_0", 256'(pkt_count_0), 256'(CNT_EN ? 1 : 0));

        // Round-robin with both inputs busy: 0,1,0,1
        do_reset();
        cfg_strict_prio = 1'b0;
        run_both(1'b0);
        settle();
        chk("t2_count_0", 256'(pkt_count_0), 256'(CNT_EN ? 2 : 0));
        chk("t2_count_1", 256'(pkt_count_1), 256'(CNT_EN ? 2 : 0));

        // Strict priority: input 0 always wins; input 1 only when input 0 idles
        do_reset();
        cfg_strict_prio = 1'b1;
        run_both(1'b1);
        set_src(1, 1'b1, 7, 0, 1'b1);
        settle();
        chk("t3_idle_vld", 256'(m_axis_tvalid), 256'(0));
        tick();
        settle();
        chk("t3_in1_dat", m_axis_tdata, enc(1, 7, 0));
        chk("t3_in1_rdy1", 256'(s_axis_tready_1), 256'(1));
        tick();
        set_src(1, 1'b0, 0, 0, 1'b0);
        settle();
        chk("t3_count_0", 256'(pkt_count_0), 256'(CNT_EN ? 4 : 0));
        chk("t3_count_1", 256'(pkt_count_1), 256'(CNT_EN ? 1 : 0));
        cfg_strict_prio = 1'b0;

        // Input 1 granted; downstream stalls and source valid drops mid-packet
        do_reset();
        b = 0;
        nseen = 0;
        t0_bad = 1'b0;
        for (int c = 0; c < 30 && nseen < 4; c++) begin
            set_src(1, (b < 4) && !(c == 5 || c == 6), 0, b, b == 3);
            set_src(0, c >= 1, 9, 0, 1'b1);
            m_axis_tready = !(c == 2 || c == 3);
            settle();
            if (s_axis_tready_0) t0_bad = 1'b1;
            if (c == 5) chk("t4_drop_vld", 256'(m_axis_tvalid), 256'(0));
            if (m_axis_tvalid && m_axis_tready) begin
                chk($sformatf("t4_b%0d_dat", nseen), m_axis_tdata, enc(1, 0, nseen));
                chk($sformatf("t4_b%0d_last", nseen), 256'(m_axis_tlast), 256'(nseen == 3));
                nseen++;
            end
            hs = s_axis_tvalid_1 & s_axis_tready_1;
            tick();
            if (hs) b++;
        end
        chk("t4_out_beats", 256'(nseen), 256'(4));
        chk("t4_src_beats", 256'(b), 256'(4));
        chk("t4_rdy0_low", 256'(t0_bad), 256'(0));
        set_src(0, 1'b0, 0, 0, 1'b0);
        set_src(1, 1'b0, 0, 0, 1'b0);
        m_axis_tready = 1'b1;

        // Reset mid-packet, then arbitration restarts with input 0 favoured
        do_reset();
        set_src(0, 1'b1, 0, 0, 1'b1);
        tick();
        tick();
        set_src(0, 1'b1, 1, 0, 1'b0);
        tick();
        tick();
        set_src(0, 1'b1, 1, 1, 1'b0);
        settle();
        chk("t5_pre_vld", 256'(m_axis_tvalid), 256'(1));
        #1;
        axi_aresetn = 1'b0;
        #1;
        chk("t5_rst_vld", 256'(m_axis_tvalid), 256'(0));
        chk("t5_rst_rdy0", 256'(s_axis_tready_0), 256'(0));
        chk("t5_rst_rdy1", 256'(s_axis_tready_1), 256'(0));
        chk("t5_rst_count_0", 256'(pkt_count_0), 256'(0));
        @(posedge axi_aclk);
        @(posedge axi_aclk);
        #3;
        axi_aresetn = 1'b1;
        set_src(0, 1'b1, 2, 0, 1'b1);
        set_src(1, 1'b1, 2, 0, 1'b1);
        tick();
        settle();
        chk("t5_after_dat", m_axis_tdata, enc(0, 2, 0));
        chk("t5_after_rdy0", 256'(s_axis_tready_0), 256'(1));
        chk("t5_after_rdy1", 256'(s_axis_tready_1), 256'(0));
        tick();
        set_src(0, 1'b0, 0, 0, 1'b0);
        set_src(1, 1'b0, 0, 0, 1'b0);
        settle();
        chk("t5_count_0", 256'(pkt_count_0), 256'(CNT_EN ? 1 : 0));

        // Counter wrap
        do_reset();
`ifdef CAPTURE_ARB_PKT_COUNTERS_EN
        force dut.cnt_0_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_0_q;
`endif
        set_src(0, 1'b1, 3, 0, 1'b1);
        tick();
        tick();
        set_src(0, 1'b0, 0, 0, 1'b0);
        settle();
        chk("t6_wrap_count_0", 256'(pkt_count_0), 256'(0));
        chk("t6_wrap_count_1", 256'(pkt_count_1), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
